// File: rtl/imem_stall_resp.sv
// -----------------------------------------------------------------------------
// imem_stall_resp
//
// Multi-cycle instruction-memory responder for the fetch stage.
//
// A request (read or write) is accepted in IDLE when enable=1. The block then
// sits in WAIT for LATENCY clock edges with stall=1. At the final edge it
// completes the latched request, returns to IDLE and pulses done for one
// cycle. Because the done cycle is spent in IDLE, a new request can be
// accepted at the edge that ends the done pulse. This gives one completion
// every LATENCY+1 cycles when enable is held high.
//
// Parameters
//   MEM_WORDS : number of 16-bit words stored (power of two, 2..32768)
//   LATENCY   : edges from acceptance to completion (1..15)
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst       in   1   asynchronous active-high reset
//   addr      in   16  byte address; word index = addr[15:1] mod MEM_WORDS
//   data_in   in   16  write data, used only when wr=1
//   enable    in   1   request valid, sampled only in IDLE
//   wr        in   1   1 = write, 0 = read; sampled with enable
//   data_out  out  16  read data (or written data); held until next done
//   stall     out  1   high while a request is outstanding (state WAIT)
//   done      out  1   one-cycle completion pulse
//   err       out  1   high with done when the request had addr[0]=1
// -----------------------------------------------------------------------------
module imem_stall_resp #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        enable,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    // Counter is loaded with LATENCY-1 so that the completing edge is the
    // LATENCY-th edge after the accepting edge.
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_WAIT = 1'b1;

    // Storage. Not reset: contents survive rst.
    logic [15:0] mem [MEM_WORDS];

    // Registered state
    logic             state_q,    state_d;
    logic [3:0]       cnt_q,      cnt_d;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic             mis_q,      mis_d;
    logic [15:0]      din_q,      din_d;
    logic             wr_q,       wr_d;
    logic [15:0]      data_out_q, data_out_d;
    logic             done_q,     done_d;
    logic             err_q,      err_d;

    logic             mem_we;
    logic [15:0]      mem_rdata;

    // Only addr[0] and the low IDX_W bits of the word index are meaningful;
    // the upper address bits wrap by design and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^addr;

    assign mem_rdata = mem[idx_q];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        mis_d      = mis_q;
        din_d      = din_q;
        wr_d       = wr_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mem_we     = 1'b0;

        case (state_q)
            STATE_IDLE: begin
                if (enable) begin
                    idx_d   = addr[IDX_W:1];
                    mis_d   = addr[0];
                    din_d   = data_in;
                    wr_d    = wr;
                    cnt_d   = LAT_M1;
                    state_d = STATE_WAIT;
                end
            end

            STATE_WAIT: begin
                // Inputs are deliberately not looked at here: the request was
                // frozen at acceptance.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = STATE_IDLE;
                    done_d  = 1'b1;
                    if (mis_q) begin
                        // Misaligned: no memory access at all, not even a read.
                        data_out_d = 16'h0000;
                        err_d      = 1'b1;
                    end else if (wr_q) begin
                        mem_we     = 1'b1;
                        data_out_d = din_q;
                    end else begin
                        data_out_d = mem_rdata;
                    end
                end
            end

            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= STATE_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            mis_q      <= 1'b0;
            din_q      <= 16'h0000;
            wr_q       <= 1'b0;
            data_out_q <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            mis_q      <= mis_d;
            din_q      <= din_d;
            wr_q       <= wr_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Memory write port. mem_we can only be high in WAIT, and reset forces
    // IDLE, so a write pending when rst arrives is never performed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= din_q;
        end
    end

    assign data_out = data_out_q;
    assign stall    = (state_q == STATE_WAIT);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_imem_stall_resp.sv
// -----------------------------------------------------------------------------
// tb_imem_stall_resp
//
// Directed bench for imem_stall_resp. Two instances share clock, reset and
// request inputs: dut0 with LATENCY=2 and dut1 with LATENCY=1, each with its
// own enable. A table of single requests is applied to dut0, followed by
// hand-written sequences for back-to-back fetch, input changes during WAIT,
// reset mid-request, address wrap and the LATENCY=1 instance.
// -----------------------------------------------------------------------------
module tb_imem_stall_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        en0, en1;

    logic [15:0] data_out0, data_out1;
    logic        stall0, stall1, done0, done1, err0, err1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_stall_resp #(.MEM_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .enable(en0), .wr(wr), .data_out(data_out0), .stall(stall0),
        .done(done0), .err(err0)
    );

    imem_stall_resp #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .enable(en1), .wr(wr), .data_out(data_out1), .stall(stall1),
        .done(done1), .err(err1)
    );

    typedef struct {
        bit          w;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] ed;
        logic        ee;
    } vec_t;

    localparam int NV = 14;
    vec_t vt [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One isolated request on dut0 (sel=0) or dut1 (sel=1). Starts and ends
    // on a falling edge; checks stall length, the done pulse and its data.
    task automatic do_req(input bit sel, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] ed,
                          input logic ee, input int lat, input string nm);
        int  n;
        bit  got;
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        addr    = a;
        data_in = d;
        wr      = w;
        if (sel) en1 = 1'b1; else en0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                en0 = 1'b0;
                en1 = 1'b0;
            end
            if (sel ? done1 : done0) begin
                got = 1'b1;
                break;
            end
            if (sel ? stall1 : stall0) n++;
        end
        check({nm, " done seen"}, 32'(got), 32'd1);
        check({nm, " stall cycles"}, n, lat);
        check({nm, " data_out"}, sel ? data_out1 : data_out0, ed);
        check({nm, " err"}, sel ? err1 : err0, ee);
        check({nm, " stall at done"}, sel ? stall1 : stall0, 1'b0);
        @(negedge clk);
        check({nm, " done pulse width"}, sel ? done1 : done0, 1'b0);
        check({nm, " err cleared"}, sel ? err1 : err0, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : main
        int          k;
        int          last;
        int          seen;
        logic [15:0] b2b_exp [4];

        vt[0]  = '{1'b1, 16'h0010, 16'hA5C3, 16'hA5C3, 1'b0};
        vt[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hA5C3, 1'b0};
        vt[2]  = '{1'b1, 16'h0000, 16'h1111, 16'h1111, 1'b0};
        vt[3]  = '{1'b1, 16'h0002, 16'h2222, 16'h2222, 1'b0};
        vt[4]  = '{1'b1, 16'h0004, 16'h3333, 16'h3333, 1'b0};
        vt[5]  = '{1'b1, 16'h0006, 16'h4444, 16'h4444, 1'b0};
        vt[6]  = '{1'b1, 16'h0012, 16'h0C0C, 16'h0C0C, 1'b0};
        vt[7]  = '{1'b1, 16'h0020, 16'h5A5A, 16'h5A5A, 1'b0};
        vt[8]  = '{1'b1, 16'h0030, 16'h1234, 16'h1234, 1'b0};
        vt[9]  = '{1'b0, 16'h0013, 16'h0000, 16'h0000, 1'b1};
        vt[10] = '{1'b0, 16'h0012, 16'h0000, 16'h0C0C, 1'b0};
        vt[11] = '{1'b1, 16'h0013, 16'hFFFF, 16'h0000, 1'b1};
        vt[12] = '{1'b0, 16'h0012, 16'h0000, 16'h0C0C, 1'b0};
        vt[13] = '{1'b0, 16'h0006, 16'h0000, 16'h4444, 1'b0};

        b2b_exp[0] = 16'h1111;
        b2b_exp[1] = 16'h2222;
        b2b_exp[2] = 16'h3333;
        b2b_exp[3] = 16'h4444;

        rst     = 1'b1;
        addr    = 16'h0000;
        data_in = 16'h0000;
        wr      = 1'b0;
        en0     = 1'b0;
        en1     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset data_out", data_out0, 16'h0000);
        check("reset stall", stall0, 1'b0);
        check("reset done", done0, 1'b0);
        check("reset err", err0, 1'b0);
        check("reset stall lat1", stall1, 1'b0);
        rst = 1'b0;

        // Table of single requests on the LATENCY=2 instance
        for (int i = 0; i < NV; i++) begin
            do_req(1'b0, vt[i].w, vt[i].a, vt[i].d, vt[i].ed, vt[i].ee, 2,
                   $sformatf("vec%0d", i));
        end

        // Back-to-back fetch with enable held high
        @(negedge clk);
        addr = 16'h0000;
        wr   = 1'b0;
        en0  = 1'b1;
        k    = 0;
        last = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            @(negedge clk);
            if (done0) begin
                check($sformatf("b2b data %0d", k), data_out0, b2b_exp[k]);
                if (k > 0) check($sformatf("b2b spacing %0d", k), cyc - last, 3);
                last = cyc;
                k++;
                if (k < 4) addr = 16'(2 * k);
                else en0 = 1'b0;
            end
        end
        check("b2b done count", k, 4);
        @(negedge clk);
        check("b2b idle after", stall0, 1'b0);

        // Inputs changed during WAIT are ignored
        @(negedge clk);
        addr = 16'h0010;
        wr   = 1'b0;
        en0  = 1'b1;
        @(negedge clk);
        check("ignore stall", stall0, 1'b1);
        addr    = 16'h0020;
        wr      = 1'b1;
        data_in = 16'hDEAD;
        @(negedge clk);
        wr = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done0) begin
                seen = 1;
                en0  = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("ignore done seen", seen, 1);
        check("ignore data_out", data_out0, 16'hA5C3);
        check("ignore err", err0, 1'b0);
        do_req(1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 1'b0, 2, "ignore no write");

        // Reset in the middle of a write
        @(negedge clk);
        addr    = 16'h0030;
        data_in = 16'hBEEF;
        wr      = 1'b1;
        en0     = 1'b1;
        @(negedge clk);
        en0 = 1'b0;
        check("rstmid stall before", stall0, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("rstmid stall", stall0, 1'b0);
        check("rstmid done", done0, 1'b0);
        check("rstmid err", err0, 1'b0);
        check("rstmid data_out", data_out0, 16'h0000);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done0) seen = 1;
        end
        check("rstmid no done", seen, 0);
        do_req(1'b0, 1'b0, 16'h0030, 16'h0000, 16'h1234, 1'b0, 2, "rstmid old value");

        // Address wrap: word 0x400 aliases word 0 in a 1024-word array
        do_req(1'b0, 1'b1, 16'h0800, 16'h7E7E, 16'h7E7E, 1'b0, 2, "wrap write");
        do_req(1'b0, 1'b0, 16'h0000, 16'h0000, 16'h7E7E, 1'b0, 2, "wrap read");
        do_req(1'b0, 1'b0, 16'h0002, 16'h0000, 16'h2222, 1'b0, 2, "wrap neighbour");

        // LATENCY=1 instance
        do_req(1'b1, 1'b1, 16'h0010, 16'hA5C3, 16'hA5C3, 1'b0, 1, "lat1 write");
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, 16'hA5C3, 1'b0, 1, "lat1 read");
        do_req(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1, "lat1 misaligned");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
